// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: queued write-port driver for the 24-bit register file.
// Define WB_BYPASS_EN to build the q_data forwarding path.
module reg_writeback_unit #(
  parameter int DATA_W     = 24,
  parameter int ADDR_W     = 4,
  parameter int NUM_REGS   = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              wb_hold,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [NUM_REGS-1:0] busy,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_pending,
  output logic [DATA_W-1:0] q_data,
  output logic              init_done,
  output logic              wb_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  logic [PTR_W-1:0]    wr_q, wr_d;
  logic [PTR_W-1:0]    rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [ADDR_W-1:0]   fa_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]   fa_d [FIFO_DEPTH];
  logic [DATA_W-1:0]   fd_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fd_d [FIFO_DEPTH];
  logic                wb_err_q, wb_err_d;
  logic                full, empty;
  logic                acc, push, pop;
  logic [ADDR_W-1:0]   in_addr;
  logic [DATA_W-1:0]   in_data;

  always_comb begin
    state_d   = state_q;
    sweep_d   = sweep_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    vld_d     = vld_q;
    fa_d      = fa_q;
    fd_d      = fd_q;
    wb_err_d  = 1'b0;
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    rf_we     = 1'b0;
    rf_wa     = '0;
    rf_wd     = '0;
    acc       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    in_addr   = mem_valid ? mem_addr : alu_addr;
    in_data   = mem_valid ? mem_data : alu_data;
    full      = (cnt_q == FULL_CNT);
    empty     = (cnt_q == '0);
    if (!rst) begin
      unique case (state_q)
        S_INIT: begin
          rf_we   = 1'b1;
          rf_wa   = sweep_q;
          sweep_d = sweep_q + ADDR_W'(1);
          if (sweep_q == LAST_REG) begin
            state_d = S_RUN;
            sweep_d = '0;
          end
        end
        S_RUN: begin
          // Readies look only at occupancy, never at this cycle's pop.
          mem_ready = !full;
          alu_ready = !full && !mem_valid;
          acc = (mem_valid && mem_ready) ||
                (alu_valid && alu_ready);
          wb_err_d = acc && (in_addr > LAST_REG);
          push = acc && !wb_err_d;
          pop  = !empty && !wb_hold;
          rf_we = pop;
          if (pop) begin
            rf_wa = fa_q[rd_q];
            rf_wd = fd_q[rd_q];
          end
        end
        default: ;
      endcase
    end
    if (push) begin
      fa_d[wr_q]  = in_addr;
      fd_d[wr_q]  = in_data;
      vld_d[wr_q] = 1'b1;
      wr_d = wr_q + PTR_W'(1);
    end
    if (pop) begin
      vld_d[rd_q] = 1'b0;
      rd_d = rd_q + PTR_W'(1);
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      sweep_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      wb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      wb_err_q <= wb_err_d;
    end
  end

  always_ff @(posedge clk) begin
    fa_q <= fa_d;
    fd_q <= fd_d;
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < FIFO_DEPTH; i++)
      for (int r = 0; r < NUM_REGS; r++)
        if (vld_q[i] && fa_q[i] == ADDR_W'(r))
          busy[r] = 1'b1;
  end

  always_comb begin
    q_pending = 1'b0;
    for (int r = 0; r < NUM_REGS; r++)
      if (q_addr == ADDR_W'(r))
        q_pending = busy[r];
  end

`ifdef WB_BYPASS_EN
  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so the youngest match wins.
  always_comb begin
    q_data = '0;
    slot   = rd_q;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      slot = rd_q + PTR_W'(k);
      if (vld_q[slot] && fa_q[slot] == q_addr)
        q_data = fd_q[slot];
    end
  end
`else
  assign q_data = '0;
`endif

  assign init_done = (state_q == S_RUN);
  assign wb_err    = wb_err_q;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed and randomized checks of the writeback
// unit against a queue-level reference model.
module tb_reg_writeback_unit;

  localparam int NR = 11;
`ifdef WB_BYPASS_EN
  localparam logic [23:0] BP_QD = 24'd3;
`else
  localparam logic [23:0] BP_QD = 24'd0;
`endif

  logic        clk, rst;
  logic        alu_valid, mem_valid, wb_hold;
  logic [3:0]  alu_addr, mem_addr, q_addr;
  logic [23:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, rf_we;
  logic [3:0]  rf_wa;
  logic [23:0] rf_wd, q_data;
  logic [10:0] busy;
  logic        q_pending, init_done, wb_err;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0]  a;
    logic [23:0] d;
  } ent_t;

  ent_t mq[$];
  bit   m_init = 1'b1;
  int   m_sweep = 0;
  bit   m_err = 1'b0;

  logic        exp_we, exp_ar, exp_mr;
  logic        exp_err, exp_done, exp_qp;
  logic [3:0]  exp_wa;
  logic [23:0] exp_wd, exp_qd;
  logic [10:0] exp_busy;

  reg_writeback_unit dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready),
    .wb_hold(wb_hold),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .busy(busy), .q_addr(q_addr),
    .q_pending(q_pending), .q_data(q_data),
    .init_done(init_done), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs for the current cycle from the model and inputs.
  task automatic settle();
    @(negedge clk);
    exp_busy = '0;
    foreach (mq[i])
      for (int r = 0; r < NR; r++)
        if (mq[i].a == 4'(r)) exp_busy[r] = 1'b1;
    exp_qp = 1'b0;
    for (int r = 0; r < NR; r++)
      if (q_addr == 4'(r)) exp_qp = exp_busy[r];
    exp_qd = '0;
`ifdef WB_BYPASS_EN
    foreach (mq[i])
      if (mq[i].a == q_addr) exp_qd = mq[i].d;
`endif
    exp_err  = m_err;
    exp_done = !m_init;
    exp_we = 1'b0; exp_wa = '0; exp_wd = '0;
    exp_ar = 1'b0; exp_mr = 1'b0;
    if (rst) begin
      exp_we = 1'b0;
    end else if (m_init) begin
      exp_we = 1'b1;
      exp_wa = 4'(m_sweep);
    end else begin
      exp_mr = (mq.size() < 4);
      exp_ar = (mq.size() < 4) && !mem_valid;
      if (mq.size() > 0 && !wb_hold) begin
        exp_we = 1'b1;
        exp_wa = mq[0].a;
        exp_wd = mq[0].d;
      end
    end
  endtask

  // Advance the model across the rising edge.
  task automatic tick();
    ent_t e;
    bit acc;
    @(posedge clk);
    e = '0;
    acc = 1'b0;
    if (rst) begin
      m_init = 1'b1; m_sweep = 0; m_err = 1'b0;
      mq.delete();
    end else if (m_init) begin
      m_err = 1'b0;
      m_sweep++;
      if (m_sweep == NR) begin
        m_init = 1'b0; m_sweep = 0;
      end
    end else begin
      m_err = 1'b0;
      if (mem_valid && exp_mr) begin
        acc = 1'b1; e.a = mem_addr; e.d = mem_data;
      end else if (alu_valid && exp_ar) begin
        acc = 1'b1; e.a = alu_addr; e.d = alu_data;
      end
      if (exp_we) void'(mq.pop_front());
      if (acc) begin
        if (e.a >= 4'(NR)) m_err = 1'b1;
        else mq.push_back(e);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; alu_valid = 1'b1; mem_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if ({rf_we, alu_ready, mem_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_hold: we/ar/mr=%b want 000",
                 {rf_we, alu_ready, mem_ready});
      end
      tick();
    end
    rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    for (int i = 0; i < NR; i++) begin
      settle();
      n_checks++;
      if ({rf_we, rf_wa, rf_wd, alu_ready, mem_ready, init_done}
          !== {1'b1, 4'(i), 24'h0, 3'b000}) begin
        n_fail++;
        $display("FAIL sweep[%0d]: we=%b wa=%0d wd=%h rdy=%b%b done=%b",
                 i, rf_we, rf_wa, rf_wd, alu_ready, mem_ready, init_done);
      end
      tick();
    end
    settle();
    n_checks++;
    if ({init_done, alu_ready, mem_ready, rf_we, busy} !==
        {4'b1110, 11'h0}) begin
      n_fail++;
      $display("FAIL sweep_end: done/ar/mr/we=%b busy=%h want 1110 0",
               {init_done, alu_ready, mem_ready, rf_we}, busy);
    end
    tick();
  endtask

  task automatic test_single();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 24'h00ABCD;
    settle();
    n_checks++;
    if (alu_ready !== 1'b1 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_acc: ar=%b we=%b want 1 0", alu_ready, rf_we);
    end
    tick();
    alu_valid = 1'b0;
    settle();
    n_checks++;
    if ({rf_we, rf_wa, rf_wd, busy} !== {1'b1, 4'd3, 24'h00ABCD, 11'h008}) begin
      n_fail++;
      $display("FAIL single_wr: we=%b wa=%0d wd=%h busy=%h",
               rf_we, rf_wa, rf_wd, busy);
    end
    tick();
    settle();
    n_checks++;
    if (rf_we !== 1'b0 || busy !== 11'h0) begin
      n_fail++;
      $display("FAIL single_done: we=%b busy=%h want 0 0", rf_we, busy);
    end
    tick();
  endtask

  task automatic test_arbitration();
    mem_valid = 1'b1; mem_addr = 4'd1; mem_data = 24'h111111;
    alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 24'h222222;
    settle();
    n_checks++;
    if ({mem_ready, alu_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL arb_prio: mr/ar=%b want 10", {mem_ready, alu_ready});
    end
    tick();
    mem_valid = 1'b0;
    settle();
    n_checks++;
    if ({alu_ready, rf_we, rf_wa, rf_wd} !== {2'b11, 4'd1, 24'h111111}) begin
      n_fail++;
      $display("FAIL arb_first: ar=%b we=%b wa=%0d wd=%h",
               alu_ready, rf_we, rf_wa, rf_wd);
    end
    tick();
    alu_valid = 1'b0;
    settle();
    n_checks++;
    if ({rf_we, rf_wa, rf_wd} !== {1'b1, 4'd2, 24'h222222}) begin
      n_fail++;
      $display("FAIL arb_second: we=%b wa=%0d wd=%h", rf_we, rf_wa, rf_wd);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [3:0] adr [4];
    adr[0] = 4'd5; adr[1] = 4'd6; adr[2] = 4'd5; adr[3] = 4'd7;
    wb_hold = 1'b1; q_addr = 4'd5;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_addr = adr[i]; alu_data = 24'(i + 1);
      settle();
      n_checks++;
      if (alu_ready !== 1'b1 || rf_we !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_push[%0d]: ar=%b we=%b want 1 0", i, alu_ready, rf_we);
      end
      tick();
    end
    alu_addr = 4'd9; alu_data = 24'h0000AA;
    settle();
    n_checks++;
    if ({alu_ready, mem_ready, rf_we, busy, q_pending, q_data} !==
        {3'b000, 11'h0E0, 1'b1, BP_QD}) begin
      n_fail++;
      $display("FAIL bp_full: ar=%b mr=%b we=%b busy=%h qp=%b qd=%h",
               alu_ready, mem_ready, rf_we, busy, q_pending, q_data);
    end
    tick();
    wb_hold = 1'b0;
    settle();
    n_checks++;
    if ({alu_ready, rf_we, rf_wa, rf_wd} !== {2'b01, 4'd5, 24'd1}) begin
      n_fail++;
      $display("FAIL bp_drain0: ar=%b we=%b wa=%0d wd=%h",
               alu_ready, rf_we, rf_wa, rf_wd);
    end
    tick();
    alu_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      settle();
      n_checks++;
      if ({rf_we, rf_wa, rf_wd} !== {1'b1, adr[i], 24'(i + 1)}) begin
        n_fail++;
        $display("FAIL bp_drain%0d: we=%b wa=%0d wd=%h",
                 i, rf_we, rf_wa, rf_wd);
      end
      tick();
    end
    settle();
    n_checks++;
    if (busy !== 11'h0 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_empty: busy=%h we=%b want 0 0", busy, rf_we);
    end
    tick();
  endtask

  task automatic test_invalid_addr();
    alu_valid = 1'b1; alu_addr = 4'd11; alu_data = 24'hFFFFFF;
    settle();
    n_checks++;
    if (alu_ready !== 1'b1 || wb_err !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_acc: ar=%b err=%b want 1 0", alu_ready, wb_err);
    end
    tick();
    alu_valid = 1'b0;
    settle();
    n_checks++;
    if ({wb_err, rf_we, busy} !== {2'b10, 11'h0}) begin
      n_fail++;
      $display("FAIL inv_err: err=%b we=%b busy=%h want 1 0 0",
               wb_err, rf_we, busy);
    end
    tick();
    settle();
    n_checks++;
    if (wb_err !== 1'b0 || rf_we !== 1'b0) begin
      n_fail++;
      $display("FAIL inv_pulse: err=%b we=%b want 0 0", wb_err, rf_we);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      alu_valid = 1'($urandom_range(0, 1));
      mem_valid = 1'($urandom_range(0, 1));
      alu_addr  = 4'($urandom_range(0, 15));
      mem_addr  = 4'($urandom_range(0, 15));
      alu_data  = 24'($urandom);
      mem_data  = 24'($urandom);
      wb_hold   = ($urandom_range(0, 3) == 0);
      q_addr    = 4'($urandom_range(0, 15));
      if (c >= 390) begin
        alu_valid = 1'b0; mem_valid = 1'b0; wb_hold = 1'b0;
      end
      settle();
      n_checks++;
      if ({alu_ready, mem_ready} !== {exp_ar, exp_mr}) begin
        n_fail++;
        $display("FAIL rnd_rdy c=%0d: ar/mr=%b want %b",
                 c, {alu_ready, mem_ready}, {exp_ar, exp_mr});
      end
      n_checks++;
      if ({rf_we, rf_wa, rf_wd} !== {exp_we, exp_wa, exp_wd}) begin
        n_fail++;
        $display("FAIL rnd_wr c=%0d: we=%b wa=%0d wd=%h want %b %0d %h",
                 c, rf_we, rf_wa, rf_wd, exp_we, exp_wa, exp_wd);
      end
      n_checks++;
      if ({busy, q_pending, q_data} !== {exp_busy, exp_qp, exp_qd}) begin
        n_fail++;
        $display("FAIL rnd_sb c=%0d: busy=%h qp=%b qd=%h want %h %b %h",
                 c, busy, q_pending, q_data, exp_busy, exp_qp, exp_qd);
      end
      n_checks++;
      if ({wb_err, init_done} !== {exp_err, exp_done}) begin
        n_fail++;
        $display("FAIL rnd_stat c=%0d: err/done=%b want %b",
                 c, {wb_err, init_done}, {exp_err, exp_done});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    wb_hold = 1'b1; mem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_addr = 4'(i + 1); alu_data = 24'hC0_0000 + 24'(i + 1);
      settle();
      tick();
    end
    alu_valid = 1'b0;
    settle();
    n_checks++;
    if (busy !== 11'h00E) begin
      n_fail++;
      $display("FAIL mid_queued: busy=%h want 00e", busy);
    end
    tick();
    rst = 1'b1;
    settle();
    n_checks++;
    if ({rf_we, alu_ready, mem_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_rst: we/ar/mr=%b want 000",
               {rf_we, alu_ready, mem_ready});
    end
    tick();
    rst = 1'b0; wb_hold = 1'b0;
    for (int i = 0; i < NR; i++) begin
      settle();
      n_checks++;
      if ({rf_we, rf_wa, rf_wd, busy} !== {1'b1, 4'(i), 24'h0, 11'h0}) begin
        n_fail++;
        $display("FAIL mid_sweep[%0d]: we=%b wa=%0d wd=%h busy=%h",
                 i, rf_we, rf_wa, rf_wd, busy);
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      settle();
      n_checks++;
      if ({rf_we, busy, init_done} !== {1'b0, 11'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL mid_after[%0d]: we=%b busy=%h done=%b want 0 0 1",
                 i, rf_we, busy, init_done);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; wb_hold = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    q_addr = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_arbitration();
    test_back_pressure();
    test_invalid_addr();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
